// File: rtl/bcd_conv_arbiter_if.sv
// Signal bundle between the requesters, bcd_conv_arbiter and the shared binary-to-BCD converter.
// master is the arbiter's view; slave is the requester/converter environment's view.
interface bcd_conv_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    REQ;
  logic [32*N_REQ-1:0] BIN_FLAT;
  logic [N_REQ-1:0]    ACK;
  logic [2:0]          RESP_ID;
  logic [31:0]         BCD_OUT;
  logic                ERR;
  logic                OVF;
  logic                BUSY;
  logic                CONV_START;
  logic [31:0]         CONV_BIN;
  logic                CONV_DONE;
  logic [31:0]         CONV_BCD;

  modport master (
    input  REQ, BIN_FLAT, CONV_DONE, CONV_BCD,
    output ACK, RESP_ID, BCD_OUT, ERR, OVF, BUSY, CONV_START, CONV_BIN
  );

  modport slave (
    output REQ, BIN_FLAT, CONV_DONE, CONV_BCD,
    input  ACK, RESP_ID, BCD_OUT, ERR, OVF, BUSY, CONV_START, CONV_BIN
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one START/DONE binary-to-BCD converter among N_REQ requesters.
// Optional macro BCD_OVF_SAT_EN: out-of-range operands saturate to 99999999 with OVF, bypassing the converter.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic               CLK,
  input  logic               RST_N,
  bcd_conv_arbiter_if.master bus
);
  localparam int          CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0] OVF_LIMIT = 32'd99_999_999;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_CONV, ST_RESP, ST_GAP} state_t;

  state_t            state_reg;
  logic [2:0]        ptr_reg;
  logic              armed_reg;
  logic [CW-1:0]     cnt_reg;
  logic [N_REQ-1:0]  ack_reg;
  logic [2:0]        resp_id_reg;
  logic [31:0]       bcd_reg;
  logic              err_reg;
  logic              ovf_reg;
  logic              sat_pend_reg;
  logic              start_reg;
  logic [31:0]       conv_bin_reg;

  logic [31:0]       bin_arr [N_REQ];
  logic              grant_found;
  logic [2:0]        grant_idx;
  logic [31:0]       grant_bin;
  logic [2:0]        next_ptr;
  int                j;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bin
      assign bin_arr[gi] = bus.BIN_FLAT[32*gi +: 32];
    end
  endgenerate

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    grant_bin   = 32'd0;
    j           = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_reg) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_found && bus.REQ[j]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(j);
        grant_bin   = bin_arr[j];
      end
    end
    next_ptr = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= 3'd0;
      armed_reg    <= 1'b0;
      cnt_reg      <= '0;
      ack_reg      <= '0;
      resp_id_reg  <= 3'd0;
      bcd_reg      <= 32'd0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      sat_pend_reg <= 1'b0;
      start_reg    <= 1'b0;
      conv_bin_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            resp_id_reg <= grant_idx;
            ptr_reg     <= next_ptr;
`ifdef BCD_OVF_SAT_EN
            if (grant_bin > OVF_LIMIT) begin
              bcd_reg      <= 32'h9999_9999;
              ovf_reg      <= 1'b1;
              err_reg      <= 1'b0;
              sat_pend_reg <= 1'b1;
              state_reg    <= ST_RESP;
            end else
`endif
            begin
              conv_bin_reg <= grant_bin;
              start_reg    <= 1'b1;
              state_reg    <= ST_START;
            end
          end
        end
        ST_START: begin
          start_reg <= 1'b0;
          armed_reg <= 1'b0;
          cnt_reg   <= CW'(1);
          state_reg <= ST_CONV;
        end
        ST_CONV: begin
          // DONE left high by the previous result must be seen low once before it counts.
          if (!bus.CONV_DONE) armed_reg <= 1'b1;
          if (armed_reg && bus.CONV_DONE) begin
            bcd_reg   <= bus.CONV_BCD;
            err_reg   <= 1'b0;
            ack_reg   <= N_REQ'(1) << resp_id_reg;
            state_reg <= ST_RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            cnt_reg   <= CW'(TIMEOUT);
            bcd_reg   <= 32'd0;
            err_reg   <= 1'b1;
            ack_reg   <= N_REQ'(1) << resp_id_reg;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_RESP: begin
          // A saturated grant spends one extra RESP cycle so ACK lands one cycle after the grant.
          if (sat_pend_reg) begin
            sat_pend_reg <= 1'b0;
            ack_reg      <= N_REQ'(1) << resp_id_reg;
          end else begin
            ack_reg   <= '0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            state_reg <= ST_GAP;
          end
        end
        ST_GAP:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ACK        = ack_reg;
  assign bus.RESP_ID    = resp_id_reg;
  assign bus.BCD_OUT    = bcd_reg;
  assign bus.ERR        = err_reg;
  assign bus.OVF        = ovf_reg;
  assign bus.BUSY       = (state_reg != ST_IDLE);
  assign bus.CONV_START = start_reg;
  assign bus.CONV_BIN   = conv_bin_reg;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural converter model and a decimal reference.
// Honours BCD_OVF_SAT_EN when deciding expected saturation results.
module tb_bcd_conv_arbiter;
  localparam int N       = 4;
  localparam int TO      = 40;
  localparam int STD_LAT = 34;

  typedef struct {
    int          id;
    logic [31:0] bcd;
    logic        err;
    logic        ovf;
    int          lat;
    int          starts;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  bcd_conv_arbiter_if #(.N_REQ(N)) bus ();
  bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.master)
  );

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  int          order_q[$];
  int          stale_cyc  = 0;
  bit          never_done = 1'b0;
  logic [31:0] vals [N];

  // Decimal digits of the low eight decimal places, computed arithmetically.
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0]     r;
    longint unsigned x;
    r = 32'd0;
    x = 64'(v) % 64'd100000000;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input int id, input logic [31:0] v, input int mode);
    exp_t e;
    e.id     = id;
    e.bcd    = to_bcd(v);
    e.err    = 1'b0;
    e.ovf    = 1'b0;
    e.lat    = STD_LAT + stale_cyc;
    e.starts = 1;
    if (mode == 2) begin
      e.bcd = 32'd0;
      e.err = 1'b1;
      e.lat = TO;
    end
`ifdef BCD_OVF_SAT_EN
    if (v > 32'd99999999) begin
      e.bcd    = 32'h99999999;
      e.ovf    = 1'b1;
      e.err    = 1'b0;
      e.lat    = 1;
      e.starts = 0;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Converter model: 32 shift cycles after START; stale_cyc keeps the old DONE high a while.
  logic        done_m;
  logic [31:0] bcd_m;
  logic [31:0] op_m;
  logic        active_m;
  int          cnt_m;
  assign bus.CONV_DONE = done_m;
  assign bus.CONV_BCD  = bcd_m;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      done_m   <= 1'b0;
      bcd_m    <= 32'd0;
      op_m     <= 32'd0;
      active_m <= 1'b0;
      cnt_m    <= 0;
    end else if (bus.CONV_START) begin
      active_m <= 1'b1;
      cnt_m    <= 0;
      op_m     <= bus.CONV_BIN;
      if (stale_cyc == 0) done_m <= 1'b0;
    end else if (active_m) begin
      cnt_m <= cnt_m + 1;
      if (cnt_m + 1 == stale_cyc) done_m <= 1'b0;
      if (!never_done && cnt_m + 1 == 32 + stale_cyc) begin
        done_m   <= 1'b1;
        bcd_m    <= to_bcd(op_m);
        active_m <= 1'b0;
      end
    end
  end

  // Monitor: pops the expected entry for every ACK and checks timing around BUSY.
  initial begin : monitor
    int   cyc;
    int   rise_cyc;
    int   starts;
    int   last_lat;
    int   lat;
    int   idx;
    bit   busy_prev;
    exp_t e;
    cyc = 0; rise_cyc = 0; starts = 0; last_lat = 0; busy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        busy_prev = 1'b0;
      end else begin
        if (bus.BUSY && !busy_prev) begin
          rise_cyc = cyc;
          starts   = 0;
        end
        if (bus.CONV_START) starts++;
        if (!bus.BUSY && busy_prev) chk("busy_len", 64'(cyc - rise_cyc), 64'(last_lat + 2));
        if (bus.ACK != '0) begin
          lat      = cyc - rise_cyc;
          last_lat = lat;
          $display("ack id=%0d bcd=%08h err=%0b ovf=%0b lat=%0d",
                   bus.RESP_ID, bus.BCD_OUT, bus.ERR, bus.OVF, lat);
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].id == int'(bus.RESP_ID)) idx = k;
          if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got id %0d want no ack", bus.RESP_ID);
          end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
            chk("ack_onehot", 64'(bus.ACK), 64'(1 << e.id));
            chk("bcd_out", 64'(bus.BCD_OUT), 64'(e.bcd));
            chk("err", 64'(bus.ERR), 64'(e.err));
            chk("ovf", 64'(bus.OVF), 64'(e.ovf));
            chk("latency", 64'(lat), 64'(e.lat));
            chk("conv_starts", 64'(starts), 64'(e.starts));
          end
          if (order_q.size() > 0) chk("rr_order", 64'(bus.RESP_ID), 64'(order_q.pop_front()));
        end
        busy_prev = bus.BUSY;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},     64'(bus.ACK), 64'd0);
    chk({tag, "_busy"},    64'(bus.BUSY), 64'd0);
    chk({tag, "_start"},   64'(bus.CONV_START), 64'd0);
    chk({tag, "_convbin"}, 64'(bus.CONV_BIN), 64'd0);
    chk({tag, "_bcd"},     64'(bus.BCD_OUT), 64'd0);
    chk({tag, "_errovf"},  64'({bus.ERR, bus.OVF}), 64'd0);
    chk({tag, "_respid"},  64'(bus.RESP_ID), 64'd0);
  endtask

  // Raise the masked requests; each requester drops REQ on seeing its own ACK.
  task automatic run_batch(input logic [N-1:0] mask, input int mode);
    bit finished;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        bus.BIN_FLAT[32*i +: 32] = vals[i];
        exp_q.push_back(make_exp(i, vals[i], mode));
      end
    end
    bus.REQ  = bus.REQ | mask;
    finished = 1'b0;
    for (int n = 0; n < 60 * N + 60 && !finished; n++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++)
        if (bus.REQ[i] && bus.ACK[i]) bus.REQ[i] = 1'b0;
      if (bus.REQ == '0) finished = 1'b1;
    end
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL batch_wait: got req=%b pending want all acked", bus.REQ);
      bus.REQ = '0;
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin : stim
    int          acks;
    logic [N-1:0] mask;
    bit          seen;
    bus.REQ      = '0;
    bus.BIN_FLAT = '0;
    RST_N        = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Round-robin from pointer 0 with all four requesters held high.
    vals = '{32'd1, 32'd22, 32'd333, 32'd4444};
    for (int i = 0; i < N; i++) begin
      bus.BIN_FLAT[32*i +: 32] = vals[i];
      exp_q.push_back(make_exp(i, vals[i], 0));
    end
    exp_q.push_back(make_exp(0, vals[0], 0));
    order_q = '{0, 1, 2, 3, 0};
    bus.REQ = '1;
    acks = 0;
    for (int n = 0; n < 400 && acks < 5; n++) begin
      @(negedge CLK);
      if (bus.ACK != '0) acks++;
    end
    bus.REQ = '0;
    total++;
    if (acks < 5) begin
      bad++;
      $display("FAIL rr_wait: got %0d acks want 5", acks);
    end
    repeat (3) @(negedge CLK);

    vals[0] = 32'd12345678;
    run_batch(4'b0001, 0);

    for (int t = 0; t < 10; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        vals[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 99999999));
      run_batch(mask, 0);
    end

    stale_cyc = 3;
    vals[2]   = 32'($urandom_range(0, 99999999));
    run_batch(4'b0100, 1);
    stale_cyc = 0;

    never_done = 1'b1;
    vals[1]    = 32'd555;
    run_batch(4'b0010, 2);
    never_done = 1'b0;
    vals[3]    = 32'd7654321;
    run_batch(4'b1000, 0);

    // Asynchronous reset in the middle of a conversion.
    bus.BIN_FLAT[64 +: 32] = 32'd424242;
    bus.REQ = 4'b0100;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = bus.BUSY;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL busy_wait: got busy=0 want 1");
    end
    repeat (11) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_zero("midrst");
    bus.REQ = '0;
    exp_q.delete();
    order_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    vals[1] = 32'd99999999;
    run_batch(4'b0010, 0);

    vals[3] = 32'hFFFF_FFFF;
    run_batch(4'b1000, 0);
    vals[0] = 32'd0;
    run_batch(4'b0001, 0);

    repeat (5) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
